// File: rtl/cpu_ex_md.sv
// Execute stage: XLEN-bit ALU with WB->EX operand forwarding and a background
// iterative multiply/divide unit that owns the HI/LO registers. The MD unit runs
// one shift-add or restoring-subtract step per cycle, so ordinary ALU
// instructions keep flowing while it iterates. ID is held only when another MD
// op or an mfhi/mflo arrives while the unit is busy.
module cpu_ex_md #(
  parameter int XLEN   = 32,
  parameter int SHW    = $clog2(XLEN),
  parameter bit FWD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [5:0]      id_c_alucontrol,
  input  logic [5:0]      id_func,
  input  logic            id_c_rfbse,
  input  logic [XLEN-1:0] id_rfa,
  input  logic [XLEN-1:0] id_rfb,
  input  logic [XLEN-1:0] id_se,
  input  logic [SHW-1:0]  id_shamt,
  input  logic [4:0]      id_rs,
  input  logic [4:0]      id_rt,
  input  logic [4:0]      id_rf_waddr,
  input  logic            id_c_rfw,
  input  logic            wb_rfw,
  input  logic [4:0]      wb_waddr,
  input  logic [XLEN-1:0] wb_wdata,
  output logic            ex_stall,
  output logic            md_busy,
  output logic            p_valid,
  output logic            p_c_rfw,
  output logic [4:0]      p_rf_waddr,
  output logic [XLEN-1:0] p_alu_r,
  output logic [XLEN-1:0] p_rfb
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam int         CW     = SHW + 1;

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] hi, lo;
  logic [XLEN-1:0] md_a, md_b, md_q;
  logic            neg_res, neg_rem, div_zero;

  // Operand selection with WB->EX bypass (register 0 is never forwarded)
  logic            fwd_a, fwd_b;
  logic [XLEN-1:0] op_x, op_rt, op_y;
  assign fwd_a = FWD_EN && wb_rfw && (wb_waddr != 5'd0) && (wb_waddr == id_rs);
  assign fwd_b = FWD_EN && wb_rfw && (wb_waddr != 5'd0) && (wb_waddr == id_rt);
  assign op_x  = fwd_a ? wb_wdata : id_rfa;
  assign op_rt = fwd_b ? wb_wdata : id_rfb;
  assign op_y  = id_c_rfbse ? id_se : op_rt;

  // Map opcode-level ALU control onto the R-type function encoding
  logic [5:0]     func;
  logic [SHW-1:0] sh;
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    func = id_func;
    sh   = id_shamt;
    if (id_c_alucontrol != 6'h00) begin
      case (id_c_alucontrol)
        6'h08, 6'h09, 6'h23, 6'h2b: func = 6'h21;
        6'h0c:   func = 6'h24;
        6'h0d:   func = 6'h25;
        6'h0a:   func = 6'h2a;
        6'h0b:   func = 6'h2b;
        6'h0f: begin
          func = 6'h00;
          sh   = SHW'(XLEN / 2);
        end
        default: func = 6'h3f;
      endcase
    end
  end

  logic is_md, is_div, is_signed, is_mfhi, is_mflo, accept;
  assign is_md     = (func == 6'h18) || (func == 6'h19) || (func == 6'h1a) || (func == 6'h1b);
  assign is_div    = (func == 6'h1a) || (func == 6'h1b);
  assign is_signed = (func == 6'h18) || (func == 6'h1a);
  assign is_mfhi   = (func == 6'h10);
  assign is_mflo   = (func == 6'h12);
  assign md_busy   = (state != S_IDLE);
  assign ex_stall  = id_valid && md_busy && (is_md || is_mfhi || is_mflo);
  assign accept    = id_valid && is_md && !md_busy && !rst;

  // Magnitudes and signs captured when an MD op is accepted
  logic            sx, sy;
  logic [XLEN-1:0] abs_x, abs_y;
  assign sx    = is_signed && op_x[XLEN-1];
  assign sy    = is_signed && op_y[XLEN-1];
  assign abs_x = sx ? -op_x : op_x;
  assign abs_y = sy ? -op_y : op_y;

  // Single-cycle ALU; results outside the supported set read as zero
  logic [XLEN-1:0] alu_r;
  always_comb begin
    alu_r = '0;
    case (func)
      6'h21:   alu_r = op_x + op_y;
      6'h23:   alu_r = op_x - op_y;
      6'h24:   alu_r = op_x & op_y;
      6'h25:   alu_r = op_x | op_y;
      6'h27:   alu_r = ~(op_x | op_y);
      6'h2a:   alu_r = {{(XLEN-1){1'b0}}, ($signed(op_x) < $signed(op_y))};
      6'h2b:   alu_r = {{(XLEN-1){1'b0}}, (op_x < op_y)};
      6'h00:   alu_r = op_y << sh;
      6'h02:   alu_r = op_y >> sh;
      6'h03:   alu_r = $unsigned($signed(op_y) >>> sh);
      6'h10:   alu_r = hi;
      6'h12:   alu_r = lo;
      default: alu_r = '0;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide on magnitudes
  logic [XLEN:0]   mul_sum, div_sh;
  logic [XLEN-1:0] div_diff, a_nx, q_nx;
  logic            div_ge;
  always_comb begin
    mul_sum  = {1'b0, md_a} + (md_q[0] ? {1'b0, md_b} : '0);
    div_sh   = {md_a, md_q[XLEN-1]};
    div_ge   = (div_sh >= {1'b0, md_b});
    div_diff = div_sh[XLEN-1:0] - md_b;
    if (state == S_DIV) begin
      a_nx = div_ge ? div_diff : div_sh[XLEN-1:0];
      q_nx = {md_q[XLEN-2:0], div_ge};
    end else begin
      a_nx = mul_sum[XLEN:1];
      q_nx = {mul_sum[0], md_q[XLEN-1:1]};
    end
  end

  // Sign fixup applied to the final step; divide by zero forces an all-ones quotient
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  assign prod = neg_res ? -{a_nx, q_nx} : {a_nx, q_nx};
  assign quo  = div_zero ? '1 : (neg_res ? -q_nx : q_nx);
  assign rem  = neg_rem ? -a_nx : a_nx;

  // MD control FSM: accept, count XLEN steps, commit HI/LO on the last one
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state    <= is_div ? S_DIV : S_MUL;
            cnt      <= CW'(XLEN);
            neg_res  <= sx ^ sy;
            neg_rem  <= sx;
            div_zero <= is_div && (op_y == '0);
          end
        end
        S_MUL, S_DIV: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= S_IDLE;
            if (state == S_DIV) begin
              hi <= rem;
              lo <= quo;
            end else begin
              hi <= prod[2*XLEN-1:XLEN];
              lo <= prod[XLEN-1:0];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // MD working registers: loaded on accept, stepped while busy
  always_ff @(posedge clk) begin
    // NOTE: pure datapath, always loaded on accept before use, so it carries no reset.
    if (state == S_IDLE) begin
      if (accept) begin
        md_a <= '0;
        md_b <= is_div ? abs_y : abs_x;
        md_q <= is_div ? abs_x : abs_y;
      end
    end else begin
      md_a <= a_nx;
      md_q <= q_nx;
    end
  end

  // EX/MEM pipeline register; reset, empty ID and stalls all load a bubble
  always_ff @(posedge clk) begin
    if (rst || !id_valid || ex_stall) begin
      p_valid    <= 1'b0;
      p_c_rfw    <= 1'b0;
      p_rf_waddr <= '0;
      p_alu_r    <= '0;
      p_rfb      <= '0;
    end else begin
      p_valid    <= 1'b1;
      p_c_rfw    <= id_c_rfw && !is_md;
      p_rf_waddr <= id_rf_waddr;
      p_alu_r    <= alu_r;
      p_rfb      <= op_rt;
    end
  end

endmodule

// File: tb/tb_cpu_ex_md.sv
// Bench for cpu_ex_md: directed cases then randomized instruction streams on a
// 32-bit and a 16-bit instance, compared against an arithmetic reference model.
module tb_cpu_ex_md;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel16;
  logic        id_valid, rfbse, c_rfw, wb_rfw;
  logic [5:0]  ctl, func;
  logic [31:0] rfa, rfb, se, wb_wdata;
  logic [4:0]  shamt, rs, rt, waddr, wb_waddr;

  logic        s32, b32, v32, w32, s16, b16, v16, w16;
  logic [4:0]  a32, a16;
  logic [31:0] r32, d32;
  logic [15:0] r16, d16;

  cpu_ex_md #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .id_valid(id_valid & ~sel16), .id_c_alucontrol(ctl),
    .id_func(func), .id_c_rfbse(rfbse), .id_rfa(rfa), .id_rfb(rfb), .id_se(se),
    .id_shamt(shamt), .id_rs(rs), .id_rt(rt), .id_rf_waddr(waddr), .id_c_rfw(c_rfw),
    .wb_rfw(wb_rfw), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .ex_stall(s32),
    .md_busy(b32), .p_valid(v32), .p_c_rfw(w32), .p_rf_waddr(a32), .p_alu_r(r32), .p_rfb(d32)
  );

  cpu_ex_md #(.XLEN(16)) dut16 (
    .clk(clk), .rst(rst), .id_valid(id_valid & sel16), .id_c_alucontrol(ctl),
    .id_func(func), .id_c_rfbse(rfbse), .id_rfa(rfa[15:0]), .id_rfb(rfb[15:0]), .id_se(se[15:0]),
    .id_shamt(shamt[3:0]), .id_rs(rs), .id_rt(rt), .id_rf_waddr(waddr), .id_c_rfw(c_rfw),
    .wb_rfw(wb_rfw), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata[15:0]), .ex_stall(s16),
    .md_busy(b16), .p_valid(v16), .p_c_rfw(w16), .p_rf_waddr(a16), .p_alu_r(r16), .p_rfb(d16)
  );

  logic        o_stall;
  logic [71:0] o_vec;
  assign o_stall = sel16 ? s16 : s32;
  assign o_vec   = sel16 ? {v16, w16, a16, 16'h0, r16, 16'h0, d16, b16}
                         : {v32, w32, a32, r32, d32, b32};

  // Reference model state
  int              vectors = 0;
  int              miscompares = 0;
  int              busy_left = 0;
  longint unsigned m_hi = 0, m_lo = 0, pend_hi = 0, pend_lo = 0;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(longint unsigned v, int w);
    return v[w-1] ? longint'(v) - (longint'(1) << w) : longint'(v);
  endfunction

  function automatic longint unsigned alu_model(int w, logic [5:0] c, logic [5:0] f,
                                                longint unsigned x, longint unsigned y, int sh);
    longint unsigned mask = (64'd1 << w) - 1;
    logic [5:0] op = f;
    if (c != 6'h00) begin
      case (c)
        6'h08, 6'h09, 6'h23, 6'h2b: op = 6'h21;
        6'h0c: op = 6'h24;
        6'h0d: op = 6'h25;
        6'h0a: op = 6'h2a;
        6'h0b: op = 6'h2b;
        6'h0f: begin op = 6'h00; sh = w / 2; end
        default: op = 6'h3f;
      endcase
    end
    case (op)
      6'h21: return (x + y) & mask;
      6'h23: return (x - y) & mask;
      6'h24: return x & y;
      6'h25: return x | y;
      6'h27: return ~(x | y) & mask;
      6'h2a: return (sx(x, w) < sx(y, w)) ? 1 : 0;
      6'h2b: return (x < y) ? 1 : 0;
      6'h00: return (y << sh) & mask;
      6'h02: return y >> sh;
      6'h03: return longint'(sx(y, w) >>> sh) & mask;
      default: return 0;
    endcase
  endfunction

  function automatic void md_model(int w, logic [5:0] f, longint unsigned x, longint unsigned y,
                                   output longint unsigned hi, output longint unsigned lo);
    longint unsigned mask = (64'd1 << w) - 1;
    longint unsigned p;
    hi = 0;
    lo = 0;
    case (f)
      6'h18, 6'h19: begin
        p  = (f == 6'h18) ? longint'(sx(x, w) * sx(y, w)) : x * y;
        hi = (p >> w) & mask;
        lo = p & mask;
      end
      default: begin
        if (y == 0) begin
          lo = mask;
          hi = x;
        end else if (f == 6'h1a) begin
          lo = longint'(sx(x, w) / sx(y, w)) & mask;
          hi = longint'(sx(x, w) % sx(y, w)) & mask;
        end else begin
          lo = x / y;
          hi = x % y;
        end
      end
    endcase
  endfunction

  // Apply one cycle: check ex_stall before the edge and EX/MEM + md_busy after it
  task automatic step(output bit stalled);
    int              w = sel16 ? 16 : 32;
    longint unsigned mask = (64'd1 << w) - 1;
    longint unsigned x, rtv, y, er;
    bit              md, mfh, mfl, ev, ew;
    logic [4:0]      ea;
    @(negedge clk);
    x   = ((wb_rfw && wb_waddr != 0 && wb_waddr == rs) ? wb_wdata : rfa) & mask;
    rtv = ((wb_rfw && wb_waddr != 0 && wb_waddr == rt) ? wb_wdata : rfb) & mask;
    y   = rfbse ? (se & mask) : rtv;
    md  = (ctl == 0) && (func inside {6'h18, 6'h19, 6'h1a, 6'h1b});
    mfh = (ctl == 0) && (func == 6'h10);
    mfl = (ctl == 0) && (func == 6'h12);
    stalled = id_valid && (busy_left > 0) && (md || mfh || mfl);
    check("ex_stall", 72'(o_stall), 72'(stalled));
    if (rst || !id_valid || stalled) begin
      ev = 0; ew = 0; ea = 0; er = 0; rtv = 0;
    end else begin
      ev = 1;
      ew = c_rfw && !md;
      ea = waddr;
      er = mfh ? m_hi : mfl ? m_lo : md ? 0 : alu_model(w, ctl, func, x, y, int'(shamt) & (w - 1));
    end
    if (rst) begin
      busy_left = 0; m_hi = 0; m_lo = 0;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin m_hi = pend_hi; m_lo = pend_lo; end
    end else if (id_valid && md) begin
      md_model(w, func, x, y, pend_hi, pend_lo);
      busy_left = w;
    end
    @(posedge clk);
    #1;
    check("ex_mem", o_vec, {ev, ew, ea, er[31:0], rtv[31:0], busy_left > 0});
  endtask

  task automatic r_op(logic [5:0] f, logic [31:0] a, logic [31:0] b, logic [4:0] sh);
    id_valid = 1; ctl = 0; func = f; rfbse = 0; rfa = a; rfb = b; se = 32'h0; shamt = sh;
    rs = 5'd1; rt = 5'd2; waddr = 5'd3; c_rfw = 1; wb_rfw = 0; wb_waddr = 0; wb_wdata = 0;
  endtask

  task automatic i_op(logic [5:0] c, logic [31:0] a, logic [31:0] imm);
    r_op(6'h3f, a, 32'hDEAD_BEEF, 5'd0);
    ctl = c; rfbse = 1; se = imm;
  endtask

  task automatic run1();
    bit st;
    step(st);
  endtask

  // Keep the instruction in ID until it is no longer stalled (bounded)
  task automatic hold(input string tag);
    bit st;
    int n = 0;
    do begin step(st); n++; end while (st && n < 48);
    check(tag, 72'(st), 72'(0));
  endtask

  task automatic idle(int n);
    r_op(6'h21, 0, 0, 0);
    id_valid = 0;
    repeat (n) run1();
  endtask

  function automatic logic [31:0] rval();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_8000;
      4: return 32'($urandom_range(0, 20));
      5: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  logic [5:0] alu_f[13] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h2b,
                            6'h00, 6'h02, 6'h03, 6'h01, 6'h08, 6'h3f};
  logic [5:0] imm_c[10] = '{6'h08, 6'h09, 6'h23, 6'h2b, 6'h0c, 6'h0d, 6'h0a, 6'h0b, 6'h0f, 6'h04};

  task automatic rand_run(int n);
    for (int i = 0; i < n; i++) begin
      int k = $urandom_range(0, 9);
      id_valid = ($urandom_range(0, 7) != 0);
      rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); waddr = 5'($urandom);
      c_rfw = 1'($urandom); rfbse = 1'($urandom); shamt = 5'($urandom);
      rfa = rval(); rfb = rval(); se = rval();
      wb_rfw = 1'($urandom); wb_waddr = 5'($urandom_range(0, 7)); wb_wdata = rval();
      func = 6'($urandom); ctl = 0;
      if (k < 4)      func = alu_f[$urandom_range(0, 12)];
      else if (k < 6) ctl = imm_c[$urandom_range(0, 9)];
      else if (k < 8) begin func = 6'h18 + 6'($urandom_range(0, 3)); rfbse = 0; end
      else            func = $urandom_range(0, 1) ? 6'h10 : 6'h12;
      run1();
    end
  endtask

  task automatic reset_mid_div(logic [31:0] a, logic [31:0] b);
    r_op(6'h1a, a, b, 0); run1();
    idle(5);
    rst = 1; run1();
    rst = 0;
    r_op(6'h10, 0, 0, 0); run1();
    r_op(6'h12, 0, 0, 0); run1();
  endtask

  initial begin
    sel16 = 0; rst = 1;
    idle(2);
    rst = 0;

    // ALU basics and boundary compares
    r_op(6'h21, 32'h7FFF_FFFF, 32'h1, 0); run1();
    r_op(6'h2a, 32'h7FFF_FFFF, 32'h1, 0); run1();
    r_op(6'h2b, 32'h7FFF_FFFF, 32'h1, 0); run1();
    r_op(6'h2a, 32'h8000_0000, 32'h1, 0); run1();
    r_op(6'h2b, 32'h8000_0000, 32'h1, 0); run1();
    r_op(6'h03, 0, 32'h8000_00F0, 5'd4); run1();
    r_op(6'h02, 0, 32'h8000_00F0, 5'd4); run1();
    r_op(6'h00, 0, 32'h8000_00F1, 5'd31); run1();
    i_op(6'h08, 32'h7FFF_FFFF, 32'h1); run1();
    i_op(6'h0f, 32'h0, 32'h0000_1234); run1();
    i_op(6'h0b, 32'h5, 32'hFFFF_FFFF); run1();

    // Forwarding: r5 in WB overrides stale read; r0 never forwards
    r_op(6'h21, 32'h0, 32'h0, 0); rs = 5'd5; wb_rfw = 1; wb_waddr = 5'd5; wb_wdata = 32'h1234; run1();
    r_op(6'h21, 32'h55, 32'h0, 0); rs = 5'd0; wb_rfw = 1; wb_waddr = 5'd0; wb_wdata = 32'h1234; run1();
    r_op(6'h21, 32'h1, 32'h0, 0); rt = 5'd5; wb_rfw = 1; wb_waddr = 5'd5; wb_wdata = 32'h77; run1();

    // mult -3*7 with an addu slipping through, then a held mflo
    r_op(6'h18, 32'hFFFF_FFFD, 32'h7, 0); run1();
    r_op(6'h21, 32'h2, 32'h3, 0); run1();
    r_op(6'h12, 0, 0, 0); hold("mflo_wait");
    r_op(6'h10, 0, 0, 0); run1();

    // multu, div, divu by zero, div MIN/-1
    r_op(6'h19, 32'h8000_0000, 32'h2, 0); run1();
    r_op(6'h10, 0, 0, 0); hold("mfhi_wait"); r_op(6'h12, 0, 0, 0); run1();
    r_op(6'h1a, 32'hFFFF_FFF9, 32'h2, 0); run1();
    idle(10);
    r_op(6'h12, 0, 0, 0); hold("div_wait"); r_op(6'h10, 0, 0, 0); run1();
    r_op(6'h1b, 32'h7, 32'h0, 0); run1();
    r_op(6'h1b, 32'h9, 32'h1, 0); hold("md_reissue");
    r_op(6'h12, 0, 0, 0); hold("divu_wait"); r_op(6'h10, 0, 0, 0); run1();
    r_op(6'h1a, 32'h8000_0000, 32'hFFFF_FFFF, 0); run1();
    r_op(6'h12, 0, 0, 0); hold("min_wait"); r_op(6'h10, 0, 0, 0); run1();

    rand_run(400);
    reset_mid_div(32'hFFFF_FFF9, 32'h3);

    // Same checks on the 16-bit instance
    sel16 = 1; rst = 1; idle(1); rst = 0;
    r_op(6'h18, 32'hFFFF_FFFD, 32'h7, 0); run1();
    r_op(6'h12, 0, 0, 0); hold("mflo16_wait"); r_op(6'h10, 0, 0, 0); run1();
    i_op(6'h0f, 32'h0, 32'h0000_00AB); run1();
    rand_run(300);
    reset_mid_div(32'h0000_8000, 32'h0000_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
